// File: rtl/tft_spi_tx.sv
// Byte-level SPI mode-0 transmitter for the TFT panel: one byte plus D/C flag per
// request, MSB first, with CS framing and a busy handshake back to the requester.
module tft_spi_tx #(
  parameter int CLK_DIV = 2,
  parameter int CS_HOLD = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tft_transmit,
  input  logic       tft_dc,
  input  logic [7:0] tft_data,
  output logic       tft_busy,
  output logic       spi_sck,
  output logic       spi_mosi,
  output logic       spi_cs,
  output logic       spi_dc
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int HW = $clog2(CS_HOLD) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t          state, state_n;
  logic [DW-1:0]   div_cnt;
  logic [HW-1:0]   hold_cnt;
  logic [2:0]      bit_cnt;
  logic [6:0]      sh;
  logic            busy_r;

  logic div_wrap, sck_fall, last_bit, hold_done;

  assign div_wrap  = (div_cnt == DW'(CLK_DIV - 1));
  assign sck_fall  = div_wrap & spi_sck;
  assign last_bit  = (bit_cnt == 3'd7);
  assign hold_done = (hold_cnt == HW'(CS_HOLD - 1));

  // Busy is raised combinationally in the strobe cycle so a requester gating
  // on ~tft_busy can never issue two strobes back-to-back.
  assign tft_busy = busy_r | (tft_transmit & (state == IDLE));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (tft_transmit)         state_n = SHIFT;
      SHIFT:   if (sck_fall && last_bit) state_n = HOLD;
      HOLD:    if (hold_done)            state_n = IDLE;
      default:                           state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs   <= 1'b1;
      spi_dc   <= 1'b0;
      busy_r   <= 1'b0;
      div_cnt  <= '0;
      hold_cnt <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
    end else begin
      case (state)
        IDLE: if (tft_transmit) begin
          sh       <= tft_data[6:0];
          spi_mosi <= tft_data[7];
          spi_dc   <= tft_dc;
          spi_cs   <= 1'b0;
          spi_sck  <= 1'b0;
          busy_r   <= 1'b1;
          bit_cnt  <= '0;
          div_cnt  <= '0;
        end
        SHIFT: begin
          if (div_wrap) begin
            div_cnt <= '0;
            spi_sck <= ~spi_sck;
            // Data changes on the falling edge so it is stable across the next rise.
            if (spi_sck) begin
              if (last_bit) begin
                spi_cs   <= 1'b1;
                spi_mosi <= 1'b0;
                hold_cnt <= '0;
              end else begin
                spi_mosi <= sh[6];
                sh       <= {sh[5:0], 1'b0};
                bit_cnt  <= bit_cnt + 3'd1;
              end
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        HOLD: begin
          if (hold_done) busy_r   <= 1'b0;
          else           hold_cnt <= hold_cnt + HW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tft_spi_tx.sv
// Randomized bench for tft_spi_tx: two configurations share one stimulus stream and
// each is compared every cycle against a timeline model of the serial waveform.
module tb_tft_spi_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tr;
  logic       dc;
  logic [7:0] data;
  logic [1:0] busy_v, sck_v, mosi_v, cs_v, dc_v;
  bit         chk_en = 1'b0;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int D = (g == 0) ? 2 : 1;
    localparam int H = (g == 0) ? 2 : 1;

    tft_spi_tx #(.CLK_DIV(D), .CS_HOLD(H)) u_dut (
      .clk(clk), .rst(rst), .tft_transmit(tr), .tft_dc(dc), .tft_data(data),
      .tft_busy(busy_v[g]), .spi_sck(sck_v[g]), .spi_mosi(mosi_v[g]),
      .spi_cs(cs_v[g]), .spi_dc(dc_v[g])
    );

    // Model: time t since the accepting edge fully determines the pin waveform.
    bit         act = 1'b0;
    int         t   = 0;
    logic [7:0] mb  = '0;
    logic       mdc = 1'b0;

    always @(posedge clk) begin
      if (rst) begin
        act = 1'b0; mdc = 1'b0;
      end else if (!act) begin
        if (tr) begin act = 1'b1; t = 0; mb = data; mdc = dc; end
      end else begin
        t++;
        if (t == 16*D + H) act = 1'b0;
      end
    end

    logic [7:0] rx;
    int  nb = 0, low_len = 0, run = 0;
    bit  ab_byte = 0, ab_busy = 0, p_sck = 0, p_cs = 1, p_busy = 0;

    always @(negedge clk) if (chk_en) begin
      bit e_run, e_sck, e_mosi;
      e_run  = act && (t < 16*D);
      e_sck  = e_run && (((t / D) % 2) == 1);
      e_mosi = e_run ? mb[7 - t/(2*D)] : 1'b0;
      chk($sformatf("cfg%0d pins{busy,sck,mosi,cs,dc}", g),
          {27'd0, busy_v[g], sck_v[g], mosi_v[g], cs_v[g], dc_v[g]},
          {27'd0, act | tr, e_sck, e_mosi, !e_run, mdc});

      // Byte framing: bits captured at SCK rises must rebuild the latched byte.
      if (rst && !cs_v[g]) ab_byte = 1;
      if (!cs_v[g]) low_len++;
      if (sck_v[g] && !p_sck) begin rx = {rx[6:0], mosi_v[g]}; nb++; end
      if (cs_v[g] && !p_cs) begin
        if (!ab_byte) begin
          chk($sformatf("cfg%0d byte", g), {24'd0, rx}, {24'd0, mb});
          chk($sformatf("cfg%0d nbits", g), nb, 8);
          chk($sformatf("cfg%0d cs_low", g), low_len, 16*D);
        end
        nb = 0; low_len = 0; ab_byte = 0;
      end

      // A busy run is one or more chained transfers, each 1+16*D+H cycles.
      if (busy_v[g]) begin run++; if (rst) ab_busy = 1; end
      if (!busy_v[g] && p_busy) begin
        if (!ab_busy) chk($sformatf("cfg%0d busy_len", g), run % (1 + 16*D + H), 0);
        run = 0; ab_busy = 0;
      end
      p_sck = sck_v[g]; p_cs = cs_v[g]; p_busy = busy_v[g];
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic strobe(input logic [7:0] b, input logic d);
    tr = 1'b1; data = b; dc = d;
    cyc(1);
    tr = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_v != 2'b00) && n < 200) begin cyc(1); n++; end
    if (n >= 200) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    rst = 1'b1; tr = 1'b0; dc = 1'b0; data = '0;
    @(posedge clk); #1 chk_en = 1'b1;
    cyc(2);
    chk("reset_cs_sck_mosi_busy", {cs_v, sck_v, mosi_v, busy_v}, 8'b11_00_00_00);
    rst = 1'b0;
    cyc(1);

    strobe(8'hC0, 1'b0);
    wait_idle();
    strobe(8'hA5, 1'b1);
    wait_idle();

    // Late strobe with a different byte must be ignored by the running transfer.
    strobe(8'hFF, 1'b0);
    cyc(9);
    strobe(8'h00, 1'b1);
    wait_idle();

    // Strobe held through the end: the next byte starts in the first idle cycle,
    // and data wiggling after acceptance must not leak into the shifted byte.
    tr = 1'b1; data = 8'h3C; dc = 1'b1;
    repeat (40) begin cyc(1); data = 8'($urandom); dc = 1'($urandom); end
    tr = 1'b0;
    wait_idle();

    strobe(8'h5A, 1'b0);
    cyc(8);
    rst = 1'b1; cyc(1); rst = 1'b0;
    strobe(8'h96, 1'b1);
    wait_idle();

    repeat (60) begin
      strobe(8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 40)) begin
        tr = ($urandom_range(0, 7) == 0); data = 8'($urandom); dc = 1'($urandom);
        cyc(1);
      end
      tr = 1'b0;
      if ($urandom_range(0, 9) == 0) begin rst = 1'b1; cyc(1); rst = 1'b0; end
      wait_idle();
      cyc($urandom_range(0, 2));
    end

    cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
